// File: rtl/cntr8_arb_pkg.sv
// Shared constants for the cntr8 arbiter: opcodes, FSM state encodings, default width.
package cntr8_arb_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_INC  = 3'd2;
  localparam logic [2:0] ST_READ = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/cntr8_arbiter_if.sv
// Requester-side bus of the cntr8 arbiter: per-requester req/op/data in, gnt/ack/rd_data/busy out.
interface cntr8_arbiter_if
  import cntr8_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);
  logic [NUM_REQ-1:0]            req;
  logic [2*NUM_REQ-1:0]          req_op;
  logic [DATA_WIDTH*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            ack;
  logic [DATA_WIDTH-1:0]         rd_data;
  logic                          busy;

  modport master (
    output req, req_op, req_data,
    input  gnt, ack, rd_data, busy
  );

  modport slave (
    input  req, req_op, req_data,
    output gnt, ack, rd_data, busy
  );
endinterface

// File: rtl/cntr8_rr_pick.sv
// Combinational picker: lowest requester at or after ptr wins, wrapping to the lowest overall.
module cntr8_rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic             any_req
);
  logic [N-1:0] ge_mask;
  logic [N-1:0] masked;

  // x & (~x + 1) isolates the lowest set bit; ptr = 0 degenerates to fixed priority
  always_comb begin
    ge_mask = ~((N'(1) << ptr) - N'(1));
    masked  = req & ge_mask;
    any_req = |req;
    if (|masked) pick = masked & (~masked + N'(1));
    else         pick = req & (~req + N'(1));
  end
endmodule

// File: rtl/cntr8_arbiter.sv
// Arbitrates NUM_REQ requesters onto one cntr8 (LOAD/INC/READ/NOP) with registered outputs.
// Define CNTR8_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module cntr8_arbiter
  import cntr8_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  cntr8_arbiter_if.slave        bus,
  output logic                  cntr_inc,
  output logic                  cntr_load,
  output logic [DATA_WIDTH-1:0] cntr_d_in,
  input  logic [DATA_WIDTH-1:0] cntr_d_out
);
  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [2:0]            state_q, state_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  busy_q, busy_d;
  logic                  cntr_inc_q, cntr_inc_d;
  logic                  cntr_load_q, cntr_load_d;
  logic [DATA_WIDTH-1:0] cntr_d_in_q, cntr_d_in_d;

  logic [NUM_REQ-1:0]    pick;
  logic                  any_req;
  logic [PTR_W-1:0]      pick_ptr;
  logic [1:0]            sel_op;
  logic [DATA_WIDTH-1:0] sel_data;

`ifdef CNTR8_ARB_FIXED_PRIO_EN
  assign pick_ptr = '0;
`else
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d, gnt_idx;

  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      if (gnt_q[i]) gnt_idx = PTR_W'(i);
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == ST_DONE)
      rr_ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

  assign pick_ptr = rr_ptr_q;
`endif

  cntr8_rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req     (bus.req),
    .ptr     (pick_ptr),
    .pick    (pick),
    .any_req (any_req)
  );

  // pick is one-hot, so the last match is the only match
  always_comb begin
    sel_op   = OP_NOP;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        sel_op   = bus.req_op[2*i +: 2];
        sel_data = bus.req_data[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ack_d       = '0;
    data_d      = data_q;
    rd_data_d   = rd_data_q;
    cntr_inc_d  = 1'b0;
    cntr_load_d = 1'b0;
    cntr_d_in_d = cntr_d_in_q;
    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (any_req) begin
          gnt_d  = pick;
          data_d = sel_data;
          case (sel_op)
            OP_LOAD: state_d = ST_LOAD;
            OP_INC:  state_d = ST_INC;
            OP_READ: state_d = ST_READ;
            default: state_d = ST_DONE;
          endcase
        end
      end
      ST_LOAD: begin
        cntr_load_d = 1'b1;
        cntr_d_in_d = data_q;
        state_d     = ST_DONE;
      end
      // data_q doubles as the remaining-increment count
      ST_INC: begin
        if (data_q != '0) begin
          cntr_inc_d = 1'b1;
          data_d     = data_q - DATA_WIDTH'(1);
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_READ: begin
        rd_data_d = cntr_d_out;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        ack_d   = gnt_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      ack_q       <= '0;
      data_q      <= '0;
      rd_data_q   <= '0;
      busy_q      <= 1'b0;
      cntr_inc_q  <= 1'b0;
      cntr_load_q <= 1'b0;
      cntr_d_in_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      data_q      <= data_d;
      rd_data_q   <= rd_data_d;
      busy_q      <= busy_d;
      cntr_inc_q  <= cntr_inc_d;
      cntr_load_q <= cntr_load_d;
      cntr_d_in_q <= cntr_d_in_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.ack     = ack_q;
  assign bus.rd_data = rd_data_q;
  assign bus.busy    = busy_q;
  assign cntr_inc    = cntr_inc_q;
  assign cntr_load   = cntr_load_q;
  assign cntr_d_in   = cntr_d_in_q;
endmodule

// File: doc/cntr8_arbiter.md
Name: cntr8_arbiter

Overview:
Shares one 8-bit loadable up-counter (cntr8) between NUM_REQ requesters. Each requester issues a command with a req/ack handshake: LOAD a value, INCrement N times, or READ the count. The arbiter picks one requester round-robin and sequences the counter's inc/load/d_in pins, then acks the requester. Sits between the requester logic and the single cntr8 instance; it is the only driver of that instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, counter/data width; must match cntr8

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  NUM_REQ  per-requester request level
req_op  input  2*NUM_REQ  per-requester opcode, slice i = [2i+1:2i]
req_data  input  DATA_WIDTH*NUM_REQ  per-requester operand, slice i = [8i+7:8i]
gnt  output  NUM_REQ  one-hot grant, held for the whole transaction
ack  output  NUM_REQ  one-cycle completion pulse to the granted requester
rd_data  output  DATA_WIDTH  count captured by READ; valid in the ack cycle
busy  output  1  high in every state except IDLE
cntr_inc  output  1  to cntr8 inc
cntr_load  output  1  to cntr8 load
cntr_d_in  output  DATA_WIDTH  to cntr8 d_in
cntr_d_out  input  DATA_WIDTH  from cntr8 d_out (registered count)

Behaviour:
- Opcodes: 00 NOP, 01 INC (req_data = repeat count), 10 LOAD (req_data = value), 11 READ.
- Reset (asynchronous, immediate): state=IDLE; gnt, ack, busy, cntr_inc, cntr_load = 0; cntr_d_in, rd_data = 0; RR pointer = 0 (requester 0 highest priority first). A transaction in flight is abandoned with no ack; the counter itself is not reset by this block.
- FSM states: IDLE, LOAD, INC, READ, DONE. All outputs are registered.
- IDLE: if any req is high, pick the first requester at or after the RR pointer (wrapping). Register gnt, op and data. Next state: NOP→DONE, LOAD→LOAD, INC→INC, READ→READ. If no req is high, stay in IDLE.
- LOAD: cntr_load=1 and cntr_d_in=data for exactly one cycle, cntr_inc=0 → DONE.
- INC: remaining=data. Each cycle with remaining≠0: cntr_inc=1, remaining-=1. When remaining==0: cntr_inc=0 → DONE. Data 0 produces zero inc cycles, and INC spends 1 cycle in the state in that case. The counter's own FF→00 wrap is transparent to this block.
- READ: rd_data<=cntr_d_out (one cycle, counter output is registered) → DONE.
- DONE: ack[granted]=1 for one cycle. rd_data holds its last value (updated only by READ). The RR pointer moves to granted+1 mod NUM_REQ. Then → IDLE with gnt cleared.
- Latency from req sampled in IDLE to ack high: LOAD 2 cycles, READ 2, NOP 1, INC data+2 (data 0 → 2).
- Handshake: the requester holds req, op and data stable until ack. It drops req in the cycle after ack. A req still high in IDLE after ack is treated as a new request and competes normally (RR pointer already advanced).
- Changes to req/op/data of the granted requester after grant are ignored, because they were captured in IDLE.
- Simultaneous requests: exactly one grant; the others wait with no loss.
- cntr_load and cntr_inc are never asserted together. Neither is asserted outside LOAD/INC.

Optional Feature:
CNTR8_ARB_FIXED_PRIO_EN — when defined, arbitration is fixed priority (lowest index wins) and the RR pointer logic is removed. When undefined (default), round-robin as above.

Decomposition:
- Package cntr8_arb_pkg: opcode constants (OP_NOP/INC/LOAD/READ), state encoding constants, default DATA_WIDTH.
- One sub-module, cntr8_rr_pick: combinational round-robin/fixed-priority picker (req vector + pointer → one-hot pick, any_req).

Test Plan:
1. Reset asserted mid-INC (data=8'h10, after 5 incs) → outputs 0 immediately, no ack, count stays 5, next grant goes to req0.
2. req2 LOAD 8'h0C, then READ → cntr_load 1 cycle with d_in=0C, ack 2 cycles after sampling; READ ack with rd_data=8'h0C.
3. req1 INC 3 after LOAD 8'hFE → exactly 3 cntr_inc cycles, ack at cycle 5, READ returns 8'h01 (wrap).
4. INC with data 0 → no cntr_inc, ack 2 cycles after sampling, count unchanged.
5. All 4 reqs held high with NOP → grants in order 0,1,2,3,0. With CNTR8_ARB_FIXED_PRIO_EN the order is 0,0,0.
6. Granted requester changes req_data during INC 4 → still exactly 4 incs. A concurrent LOAD from another requester waits and then executes.
